// File: rtl/window_gen_l2.sv
// Purpose : 3x3 sliding-window generator over a raster-scanned F x F single-channel
//           feature map, feeding the layer-2 convolution array (one instance per channel).
// Latency : 1 cycle from the accepted pixel at (row>=2, col>=2) to o_window_valid.
// Backpr. : none; the source paces the block with i_pixel_valid and all state holds
//           while it is low.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-low reset
//   i_pixel_data   B-bit pixel, row-major raster order
//   i_pixel_valid  qualifies i_pixel_data and i_sof
//   i_sof          with i_pixel_valid: this pixel is (0,0) of a new frame
//   o_window_data  9*B-bit window, element (r,c) at [(3*r+c)*B +: B], r=0 oldest row
//   o_window_valid one-cycle pulse per emitted window
//   o_frame_done   one-cycle pulse coincident with the last window of a frame

module window_gen_l2 #(
  parameter int F = 14,
  parameter int B = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [B-1:0]   i_pixel_data,
  input  logic           i_pixel_valid,
  input  logic           i_sof,
  output logic [9*B-1:0] o_window_data,
  output logic           o_window_valid,
  output logic           o_frame_done
);

  localparam int             CW   = (F > 1) ? $clog2(F) : 1;
  localparam logic [CW-1:0] LAST = CW'(F - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  // Raster position of the next expected pixel.
  logic [CW-1:0] col_q, row_q;
  logic [CW-1:0] col_d, row_d;

  // Position of the pixel on the input this cycle (i_sof overrides the counters).
  logic [CW-1:0] cur_col, cur_row;

  // Line buffers: lb_old_q holds row r-2, lb_new_q holds row r-1, indexed by column.
  logic [B-1:0] lb_old_q [F];
  logic [B-1:0] lb_new_q [F];

  // Window registers, [row][col], row 0 oldest, col 0 leftmost.
  logic [B-1:0] win_q [3][3];
  logic [B-1:0] win_d [3][3];
  logic [9*B-1:0] win_flat_d;

  logic [B-1:0] col_top, col_mid;
  logic         emit, last_px;

  // Position resolution and counter advance.
  always_comb begin
    cur_col = i_sof ? '0 : col_q;
    cur_row = i_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (i_pixel_valid) begin
      if (cur_col == LAST) begin
        col_d = '0;
        row_d = (cur_row == LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // New column entering the window: two buffered rows above the live pixel.
  always_comb begin
    col_top = lb_old_q[cur_col];
    col_mid = lb_new_q[cur_col];
  end

  // Shift window left by one column and append the new column on the right.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = col_top;
    win_d[1][2] = col_mid;
    win_d[2][2] = i_pixel_data;
  end

  always_comb begin
    win_flat_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat_d[(3*r+c)*B +: B] = win_d[r][c];
      end
    end
  end

  // A window is complete only once two earlier rows and two earlier columns exist;
  // the row gate also keeps rows of the previous frame out of the first windows.
  assign emit    = i_pixel_valid && (cur_row >= TWO) && (cur_col >= TWO);
  assign last_px = i_pixel_valid && (cur_row == LAST) && (cur_col == LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col_q          <= '0;
      row_q          <= '0;
      o_window_data  <= '0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
      for (int i = 0; i < F; i++) begin
        lb_old_q[i] <= '0;
        lb_new_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      o_window_valid <= emit;
      o_frame_done   <= last_px;
      if (i_pixel_valid) begin
        col_q             <= col_d;
        row_q             <= row_d;
        lb_old_q[cur_col] <= lb_new_q[cur_col];
        lb_new_q[cur_col] <= i_pixel_data;
        win_q             <= win_d;
      end
      // Output word only changes when a window is emitted.
      if (emit) begin
        o_window_data <= win_flat_d;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_l2.sv
// Bench for window_gen_l2: per-scenario tasks drive pixels and push expected windows,
// a negedge monitor pops and compares each emitted window.
module tb_window_gen_l2;

  localparam int F = 14;
  localparam int B = 8;

  logic           i_clk;
  logic           i_rst;
  logic [B-1:0]   i_pixel_data;
  logic           i_pixel_valid;
  logic           i_sof;
  logic [9*B-1:0] o_window_data;
  logic           o_window_valid;
  logic           o_frame_done;

  window_gen_l2 #(.F(F), .B(B)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pixel_data   (i_pixel_data),
    .i_pixel_valid  (i_pixel_valid),
    .i_sof          (i_sof),
    .o_window_data  (o_window_data),
    .o_window_valid (o_window_valid),
    .o_frame_done   (o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [9*B-1:0] win;
    logic           done;
  } exp_t;

  exp_t           sb_q[$];
  logic [9*B-1:0] got_q[$];
  int             done_cnt;
  int             errors;
  int             checks;

  function automatic logic [B-1:0] pv(input int mode, input int r, input int c);
    int v;
    v = r * F + c;
    if (mode == 1) v = 255 - v;
    return 8'(v);
  endfunction

  function automatic logic [9*B-1:0] mk_win(input int mode, input int r, input int c);
    logic [9*B-1:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[(3*rr+cc)*B +: B] = pv(mode, r - 2 + rr, c - 2 + cc);
    return w;
  endfunction

  // Nine element values listed most-significant element first.
  function automatic logic [9*B-1:0] pk9(input int a8, input int a7, input int a6,
                                         input int a5, input int a4, input int a3,
                                         input int a2, input int a1, input int a0);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Monitor / scoreboard.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst === 1'b1) begin
      if (o_window_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window got=%h required=none", o_window_data);
        end else begin
          e = sb_q.pop_front();
          if (o_window_data !== e.win || o_frame_done !== e.done) begin
            errors++;
            $display("FAIL window got=%h done=%b required=%h done=%b",
                     o_window_data, o_frame_done, e.win, e.done);
          end
        end
        got_q.push_back(o_window_data);
        if (o_frame_done === 1'b1) done_cnt++;
      end else if (o_frame_done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL frame_done_without_valid got=1 required=0");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n, input bit rand_sof);
    for (int i = 0; i < n; i++) begin
      i_pixel_valid = 1'b0;
      i_sof         = rand_sof ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge i_clk); #1;
      i_sof = 1'b0;
    end
  endtask

  task automatic drive_px(input int mode, input int r, input int c, input bit sof);
    exp_t e;
    i_pixel_data  = pv(mode, r, c);
    i_pixel_valid = 1'b1;
    i_sof         = sof;
    if (r >= 2 && c >= 2) begin
      e.win  = mk_win(mode, r, c);
      e.done = (r == F - 1 && c == F - 1);
      sb_q.push_back(e);
    end
    @(posedge i_clk); #1;
    i_pixel_valid = 1'b0;
    i_sof         = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit sof_first, input bit gaps);
    for (int r = 0; r < F; r++)
      for (int c = 0; c < F; c++) begin
        if (gaps) while ($urandom_range(0, 99) < 40) idle(1, 1'b1);
        drive_px(mode, r, c, sof_first && r == 0 && c == 0);
      end
  endtask

  task automatic start_test();
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic drain(input string name);
    idle(4, 1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_windows got=%0d_pending required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_pixel_data = '0; i_pixel_valid = 1'b0; i_sof = 1'b0;
    #12;
    checks++;
    if (o_window_data !== '0) begin errors++; $display("FAIL reset_data got=%h required=0", o_window_data); end
    checks++;
    if (o_window_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", o_window_valid); end
    checks++;
    if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", o_frame_done); end
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_single_frame();
    start_test();
    send_frame(0, 1'b1, 1'b0);
    drain("single");
    checks++;
    if (got_q.size() != 144) begin errors++; $display("FAIL single_count got=%0d required=144", got_q.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt got=%0d required=1", done_cnt); end
    if (got_q.size() == 144) begin
      checks++;
      if (got_q[0] !== pk9(30, 29, 28, 16, 15, 14, 2, 1, 0)) begin
        errors++; $display("FAIL single_first got=%h required=%h", got_q[0], pk9(30, 29, 28, 16, 15, 14, 2, 1, 0));
      end
      checks++;
      if (got_q[143] !== pk9(195, 194, 193, 181, 180, 179, 167, 166, 165)) begin
        errors++; $display("FAIL single_last got=%h required=%h", got_q[143], pk9(195, 194, 193, 181, 180, 179, 167, 166, 165));
      end
    end
  endtask

  task automatic test_edge_cols();
    start_test();
    send_frame(0, 1'b0, 1'b0);
    drain("edge");
    checks++;
    if (got_q.size() != 144) begin
      errors++; $display("FAIL edge_count got=%0d required=144", got_q.size());
    end else begin
      // Row 2 yields 12 windows, so pixel (3,2) gives window index 12.
      checks++;
      if (got_q[12] !== pk9(44, 43, 42, 30, 29, 28, 16, 15, 14)) begin
        errors++; $display("FAIL edge_win_3_2 got=%h required=%h", got_q[12], pk9(44, 43, 42, 30, 29, 28, 16, 15, 14));
      end
    end
  endtask

  task automatic test_gaps();
    start_test();
    send_frame(0, 1'b1, 1'b1);
    drain("gaps");
    checks++;
    if (got_q.size() != 144) begin errors++; $display("FAIL gaps_count got=%0d required=144", got_q.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL gaps_done_cnt got=%0d required=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    start_test();
    send_frame(0, 1'b1, 1'b0);
    send_frame(1, 1'b1, 1'b0);
    drain("b2b");
    checks++;
    if (got_q.size() != 288) begin
      errors++; $display("FAIL b2b_count got=%0d required=288", got_q.size());
    end else begin
      checks++;
      if (got_q[144] !== pk9(225, 226, 227, 239, 240, 241, 253, 254, 255)) begin
        errors++; $display("FAIL b2b_first_f2 got=%h required=%h", got_q[144], pk9(225, 226, 227, 239, 240, 241, 253, 254, 255));
      end
    end
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_cnt got=%0d required=2", done_cnt); end
  endtask

  task automatic test_sof_abort();
    start_test();
    for (int r = 0; r <= 5; r++)
      for (int c = 0; c < F; c++)
        if (r < 5 || c < 7) drive_px(0, r, c, r == 0 && c == 0);
    send_frame(1, 1'b1, 1'b0);
    drain("abort");
    // Partial frame: rows 2..4 give 36 windows, row 5 cols 2..6 give 5.
    checks++;
    if (got_q.size() != 41 + 144) begin errors++; $display("FAIL abort_count got=%0d required=185", got_q.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL abort_done_cnt got=%0d required=1", done_cnt); end
  endtask

  task automatic test_async_reset();
    start_test();
    for (int r = 0; r <= 6; r++)
      for (int c = 0; c < F; c++)
        if (r < 6 || c <= 5) drive_px(0, r, c, r == 0 && c == 0);
    // Window for pixel (6,5) is on the outputs now; reset must clear it at once.
    #1;
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_window_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b required=0", o_window_valid); end
    checks++;
    if (o_window_data !== '0) begin errors++; $display("FAIL arst_data got=%h required=0", o_window_data); end
    checks++;
    if (o_frame_done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b required=0", o_frame_done); end
    sb_q.delete();
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    start_test();
    send_frame(1, 1'b0, 1'b0);
    drain("arst");
    checks++;
    if (got_q.size() != 144) begin errors++; $display("FAIL arst_count got=%0d required=144", got_q.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL arst_done_cnt got=%0d required=1", done_cnt); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    done_cnt = 0;
    test_reset();
    test_single_frame();
    test_edge_cols();
    test_gaps();
    test_back_to_back();
    test_sof_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_gen_l2.md
Name: window_gen_L2

Overview:
Line-buffer window generator that sits directly upstream of the layer-2 convolution array. It accepts one B-bit pixel per valid cycle from a raster-scanned F x F single-channel feature map and emits every full 3x3 window (valid padding, stride 1) as a packed 9*B-bit word with a valid strobe. It is instantiated once per input channel. Windows from all ICH instances are presented to the convolution stage in lock-step.

Parameters:
F, 14, feature map width and height in pixels (F >= 3)
B, 8, pixel bit width

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset, asynchronous, active-low
i_pixel_data  input  B  incoming pixel, raster order (row-major, col 0 first)
i_pixel_valid  input  1  i_pixel_data is valid this cycle
i_sof  input  1  qualified by i_pixel_valid: this pixel is (row 0, col 0) of a new frame
o_window_data  output  9*B  3x3 window; element (r,c) at bits [(3*r+c)*B +: B], r=0 oldest row, c=0 leftmost column
o_window_valid  output  1  o_window_data holds a new window this cycle (one-cycle pulse per window)
o_frame_done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (i_rst low, async): col/row counters = 0, line buffers and window registers = 0, o_window_data = 0, o_window_valid = 0, o_frame_done = 0. Takes effect immediately mid-frame; the first pixel after release is treated as (0,0) regardless of i_sof.
- Storage: two line buffers of F entries x B bits hold rows r-2 and r-1. A 3x3 register window shifts left by one column per accepted pixel; the new column is {linebuf_oldest[col], linebuf_newer[col], i_pixel_data}.
- Counters: col 0..F-1, row 0..F-1. Advance only when i_pixel_valid=1. col wraps F-1 -> 0 with row++. At (F-1,F-1) both wrap to 0.
- Input gaps: i_pixel_valid=0 -> counters, buffers and window hold; o_window_valid=0. Arbitrary gap length and position, including mid-row.
- Window emission: an accepted pixel at (row>=2, col>=2) produces o_window_valid=1 on the next cycle. Latency is exactly 1 cycle. The window covers rows row-2..row and cols col-2..col. No output for col<2 or row<2. Each frame produces exactly (F-2)^2 windows; with default F this is 144.
- o_frame_done: asserted together with the o_window_valid that results from pixel (F-1,F-1).
- Back-to-back frames: the pixel after (F-1,F-1) is (0,0) of the next frame with no bubble. Windows never mix rows across frames, because the row>=2 gate suppresses them.
- i_sof with i_pixel_valid: that pixel is forced to (0,0) and counters continue from there. Any partial frame is abandoned with no o_frame_done. Line buffer contents are not cleared, because they are overwritten before use.
- i_sof without i_pixel_valid is ignored.
- i_sof at a pixel that is already (0,0) has no additional effect.
- Data path is pure pass-through. No arithmetic, no saturation; pixel bits are copied unchanged.
- Outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Single frame, continuous valid, pixel = row*14+col with i_sof on the first pixel -> 144 windows. First window one cycle after pixel 30 = {30,29,28,16,15,14,2,1,0} (MSB element first). Last window = {195,194,193,181,180,179,167,166,165} with o_frame_done=1.
- Same frame with i_pixel_valid toggled in a pseudo-random pattern (about 40% idle) -> identical 144 windows in the same order. o_window_valid is never asserted during an idle gap except for the 1-cycle-latency output.
- Two frames back-to-back, second frame pixel = 255 - (row*14+col) -> exactly 288 windows and two o_frame_done pulses. The first window of frame 2 = {225,226,227,239,240,241,253,254,255}.
- i_sof asserted at frame-1 pixel (5,7), then a full frame -> no o_frame_done for the aborted frame. The next 144 windows match the fresh-frame expectation.
- i_rst pulled low for 1 cycle asynchronously mid-row 6 -> all outputs 0 immediately. After release, a new full frame without i_sof yields 144 correct windows.
- Edge columns: check that no window is emitted for pixels at col 0 or 1 of any row. The window at pixel (3,2) = {44,43,42,30,29,28,16,15,14}.
